// File: rtl/muldiv_unit_if.sv
// Operand, control and result bundle between the Execute stage and the HI/LO multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic [1:0]       MdOpE;
  logic [WIDTH-1:0] data1E;
  logic [WIDTH-1:0] data2E;
  logic             WriteHiE;
  logic             WriteLoE;
  logic             ReadHiLoE;
  logic [WIDTH-1:0] HiE;
  logic [WIDTH-1:0] LoE;
  logic             BusyE;
  logic             DoneE;
  logic             StallMD;

  modport master (
    output StartE, MdOpE, data1E, data2E, WriteHiE, WriteLoE, ReadHiLoE,
    input  HiE, LoE, BusyE, DoneE, StallMD
  );

  modport slave (
    input  StartE, MdOpE, data1E, data2E, WriteHiE, WriteLoE, ReadHiLoE,
    output HiE, LoE, BusyE, DoneE, StallMD
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define MULDIV_FAST_MULT_EN to compute multiplies with a single-cycle multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   d1_q, d1_d;
  logic               is_div_q, is_div_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               divz_q, divz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               signed_op, neg1, neg2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH:0]     div_tmp;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub, quot_raw, rem_raw, quot_fix, rem_fix;
`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] mul_full;
`endif

  always_comb begin
    signed_op = ~bus.MdOpE[0];
    neg1      = signed_op & bus.data1E[WIDTH-1];
    neg2      = signed_op & bus.data2E[WIDTH-1];
    abs1      = neg1 ? (~bus.data1E + 1'b1) : bus.data1E;
    abs2      = neg2 ? (~bus.data2E + 1'b1) : bus.data2E;
`ifdef MULDIV_FAST_MULT_EN
    mul_full  = {{WIDTH{1'b0}}, abs1} * {{WIDTH{1'b0}}, abs2};
`endif

    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; restoring shift-subtract.
    div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_tmp >= {1'b0, opb_q});
    div_sub  = div_tmp[WIDTH-1:0] - opb_q;
    div_next = {(div_ge ? div_sub : div_tmp[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    quot_raw = acc_q[WIDTH-1:0];
    rem_raw  = acc_q[2*WIDTH-1:WIDTH];
    prod_fix = (s1_q ^ s2_q) ? (~acc_q + 1'b1) : acc_q;
    quot_fix = (s1_q ^ s2_q) ? (~quot_raw + 1'b1) : quot_raw;
    rem_fix  = s1_q ? (~rem_raw + 1'b1) : rem_raw;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    d1_d     = d1_q;
    is_div_d = is_div_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    divz_d   = divz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.WriteHiE) hi_d = bus.data1E;
        if (bus.WriteLoE) lo_d = bus.data1E;
        if (bus.StartE) begin
          is_div_d = bus.MdOpE[1];
          s1_d     = neg1;
          s2_d     = neg2;
          d1_d     = bus.data1E;
          divz_d   = bus.MdOpE[1] & (bus.data2E == '0);
          cnt_d    = '0;
          busy_d   = 1'b1;
          if (bus.MdOpE[1]) begin
            opb_d   = abs2;
            acc_d   = {{WIDTH{1'b0}}, abs1};
            state_d = S_RUN;
          end else begin
`ifdef MULDIV_FAST_MULT_EN
            acc_d   = mul_full;
            state_d = S_FIX;
`else
            opb_d   = abs1;
            acc_d   = {{WIDTH{1'b0}}, abs2};
            state_d = S_RUN;
`endif
          end
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (divz_q) begin
          hi_d = d1_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      d1_q     <= '0;
      is_div_q <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      d1_q     <= d1_d;
      is_div_q <= is_div_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      divz_q   <= divz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.HiE     = hi_q;
  assign bus.LoE     = lo_q;
  assign bus.BusyE   = busy_q;
  assign bus.DoneE   = done_q;
  assign bus.StallMD = busy_q & (bus.StartE | bus.ReadHiLoE | bus.WriteHiE | bus.WriteLoE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, stall, MT writes and mid-op reset.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.StartE = 1'b0; bus.MdOpE = 2'b00; bus.data1E = '0; bus.data2E = '0;
    bus.WriteHiE = 1'b0; bus.WriteLoE = 1'b0; bus.ReadHiLoE = 1'b0;
  endtask

  // Called at posedge+1; returns after DoneE is seen (or the bound expires).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int lat, output int busy_n);
    bus.StartE = 1'b1; bus.MdOpE = op; bus.data1E = a; bus.data2E = b;
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    lat = 0; busy_n = 0;
    while (bus.DoneE !== 1'b1 && lat < 100) begin
      if (bus.BusyE === 1'b1) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    hi = bus.HiE; lo = bus.LoE;
  endtask

  logic [1:0]  v_op [11];
  logic [31:0] v_a  [11];
  logic [31:0] v_b  [11];
  logic [31:0] v_hi [11];
  logic [31:0] v_lo [11];

  initial begin
    logic [31:0] hi, lo;
    int lat, busy_n, done_seen, exp_lat;

    v_op[0]=2'b00; v_a[0]=32'hFFFFFFFF; v_b[0]=32'd2;        v_hi[0]=32'hFFFFFFFF; v_lo[0]=32'hFFFFFFFE;
    v_op[1]=2'b01; v_a[1]=32'hFFFFFFFF; v_b[1]=32'd2;        v_hi[1]=32'h00000001; v_lo[1]=32'hFFFFFFFE;
    v_op[2]=2'b00; v_a[2]=32'hFFFFFFFD; v_b[2]=32'd5;        v_hi[2]=32'hFFFFFFFF; v_lo[2]=32'hFFFFFFF1;
    v_op[3]=2'b10; v_a[3]=32'hFFFFFFF9; v_b[3]=32'd2;        v_hi[3]=32'hFFFFFFFF; v_lo[3]=32'hFFFFFFFD;
    v_op[4]=2'b11; v_a[4]=32'd100;      v_b[4]=32'd7;        v_hi[4]=32'd2;        v_lo[4]=32'd14;
    v_op[5]=2'b11; v_a[5]=32'd100;      v_b[5]=32'd0;        v_hi[5]=32'd100;      v_lo[5]=32'hFFFFFFFF;
    v_op[6]=2'b10; v_a[6]=32'h80000000; v_b[6]=32'hFFFFFFFF; v_hi[6]=32'h00000000; v_lo[6]=32'h80000000;
    v_op[7]=2'b10; v_a[7]=32'd7;        v_b[7]=32'hFFFFFFFE; v_hi[7]=32'd1;        v_lo[7]=32'hFFFFFFFD;
    v_op[8]=2'b10; v_a[8]=32'hFFFFFFF9; v_b[8]=32'd0;        v_hi[8]=32'hFFFFFFF9; v_lo[8]=32'hFFFFFFFF;
    v_op[9]=2'b01; v_a[9]=32'h12345678; v_b[9]=32'h100;      v_hi[9]=32'h00000012; v_lo[9]=32'h34567800;
    v_op[10]=2'b11; v_a[10]=32'hFFFFFFFF; v_b[10]=32'h10;    v_hi[10]=32'hF;       v_lo[10]=32'h0FFFFFFF;

    clear_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_hi", bus.HiE, 0);
    check_val("rst_lo", bus.LoE, 0);
    check_val("rst_busy", bus.BusyE, 0);
    check_val("rst_done", bus.DoneE, 0);
    check_val("rst_stall", bus.StallMD, 0);

    for (int i = 0; i < 11; i++) begin
      run_op(v_op[i], v_a[i], v_b[i], hi, lo, lat, busy_n);
      exp_lat = v_op[i][1] ? DIV_LAT : MUL_LAT;
      $display("op%0d md=%0d a=%08h b=%08h -> hi=%08h lo=%08h lat=%0d", i, v_op[i], v_a[i], v_b[i], hi, lo, lat);
      check_val($sformatf("v%0d_hi", i), hi, v_hi[i]);
      check_val($sformatf("v%0d_lo", i), lo, v_lo[i]);
      check_val($sformatf("v%0d_lat", i), lat, exp_lat);
      check_val($sformatf("v%0d_busy", i), busy_n, exp_lat);
      check_val($sformatf("v%0d_busy_end", i), bus.BusyE, 0);
      @(posedge clk); #1;
      check_val($sformatf("v%0d_done_pulse", i), bus.DoneE, 0);
    end

    // Requests arriving while busy must stall and be ignored.
    bus.StartE = 1'b1; bus.MdOpE = 2'b11; bus.data1E = 32'd100; bus.data2E = 32'd7;
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    bus.ReadHiLoE = 1'b1; bus.StartE = 1'b1; bus.WriteLoE = 1'b1;
    bus.MdOpE = 2'b01; bus.data1E = 32'd3; bus.data2E = 32'd4;
    #1 check_val("stall_busy", bus.StallMD, 1);
    repeat (3) begin @(posedge clk); #1; end
    check_val("stall_hold", bus.StallMD, 1);
    clear_inputs();
    #1 check_val("stall_drop", bus.StallMD, 0);
    lat = 0;
    while (bus.DoneE !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    $display("stall op -> hi=%08h lo=%08h", bus.HiE, bus.LoE);
    check_val("stall_done_seen", bus.DoneE, 1);
    check_val("stall_lo", bus.LoE, 14);
    check_val("stall_hi", bus.HiE, 2);
    @(posedge clk); #1;
    check_val("stall_no_restart", bus.BusyE, 0);
    bus.ReadHiLoE = 1'b1;
    #1 check_val("idle_read_nostall", bus.StallMD, 0);
    bus.ReadHiLoE = 1'b0;

    bus.WriteLoE = 1'b1; bus.data1E = 32'h1234;
    @(posedge clk); #1;
    bus.WriteLoE = 1'b0; bus.WriteHiE = 1'b1; bus.data1E = 32'h5678;
    $display("mtlo 1234 -> lo=%08h hi=%08h", bus.LoE, bus.HiE);
    check_val("mtlo_lo", bus.LoE, 32'h1234);
    check_val("mtlo_hi_kept", bus.HiE, 2);
    @(posedge clk); #1;
    clear_inputs();
    $display("mthi 5678 -> hi=%08h", bus.HiE);
    check_val("mthi_hi", bus.HiE, 32'h5678);

    // Reset in the middle of a divide.
    bus.StartE = 1'b1; bus.MdOpE = 2'b10; bus.data1E = 32'd100; bus.data2E = 32'd7;
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    $display("mid-op reset -> hi=%08h lo=%08h busy=%0b", bus.HiE, bus.LoE, bus.BusyE);
    check_val("mrst_hi", bus.HiE, 0);
    check_val("mrst_lo", bus.LoE, 0);
    check_val("mrst_busy", bus.BusyE, 0);
    check_val("mrst_done", bus.DoneE, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.DoneE === 1'b1 || bus.BusyE === 1'b1) done_seen++;
    end
    check_val("mrst_no_done", done_seen, 0);
    run_op(2'b00, 32'd3, 32'd4, hi, lo, lat, busy_n);
    $display("post-reset mult 3x4 -> hi=%08h lo=%08h lat=%0d", hi, lo, lat);
    check_val("post_lo", lo, 12);
    check_val("post_hi", hi, 0);
    check_val("post_lat", lat, MUL_LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
